// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU FunSel codes, flag bit positions and sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [4:0] FS_PASS_A  = 5'b10000;
    localparam logic [4:0] FS_PASS_B  = 5'b10001;
    localparam logic [4:0] FS_NOT_A   = 5'b10010;
    localparam logic [4:0] FS_NOT_B   = 5'b10011;
    localparam logic [4:0] FS_ADD32   = 5'b10100;
    localparam logic [4:0] FS_ADDC32  = 5'b10101;
    localparam logic [4:0] FS_SUB32   = 5'b10110;
    localparam logic [4:0] FS_AND32   = 5'b10111;

    // Bit positions inside the {Z,C,N,O} flag nibble
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        FLAG = 2'd2
    } seq_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : Shift-and-add unsigned multiplier that borrows the shared ALU
//            for every addition and optionally for the final flag update.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int         WIDTH      = 16,
    parameter logic [4:0] ADD_FUNSEL = FS_ADD32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Multiplicand,
    input  logic [WIDTH-1:0] Multiplier,
    input  logic             SetFlags,
    output logic             Busy,
    output logic             Done,
    output logic [31:0]      Product,
    output logic [31:0]      ALU_A,
    output logic [31:0]      ALU_B,
    output logic [4:0]       ALU_FunSel,
    output logic             ALU_WF,
    input  logic [31:0]      ALUOut
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_count = CW'(WIDTH - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [31:0]      r_acc;
    logic [31:0]      r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [CW-1:0]    r_count;
    logic             r_sf;
    logic             r_done;
    logic [31:0]      r_product;
    logic             w_last_step;

    // Stop early once no set multiplier bits remain above the current one
    assign w_last_step = ((r_mplr >> 1) == '0) || (r_count == c_last_count);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ALU_A       = '0;
        ALU_B       = '0;
        ALU_FunSel  = ADD_FUNSEL;
        ALU_WF      = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = (Multiplier == '0) ? FLAG : STEP;
                end
            end
            STEP: begin
                ALU_A = r_acc;
                ALU_B = r_mcand;
                if (w_last_step) begin
                    w_state_nxt = FLAG;
                end
            end
            FLAG: begin
                ALU_A       = r_acc;
                ALU_WF      = r_sf;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_count   <= '0;
            r_sf      <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= (r_state == FLAG);
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_acc   <= '0;
                        r_mcand <= {{(32-WIDTH){1'b0}}, Multiplicand};
                        r_mplr  <= Multiplier;
                        r_count <= '0;
                        r_sf    <= SetFlags;
                    end
                end
                STEP: begin
                    if (r_mplr[0]) begin
                        r_acc <= ALUOut;
                    end
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_count <= r_count + CW'(1);
                end
                FLAG: begin
                    r_product <= r_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy    = (r_state != IDLE);
    assign Done    = r_done;
    assign Product = r_product;

endmodule : alu_mul_sequencer
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Randomized self-checking bench with a small ALU model attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [15:0] Multiplicand;
    logic [15:0] Multiplier;
    logic        SetFlags;
    logic        Busy;
    logic        Done;
    logic [31:0] Product;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [31:0] ALUOut;
    logic [3:0]  r_flags;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] prev_product;

    alu_mul_sequencer #(.WIDTH(16), .ADD_FUNSEL(FS_ADD32)) u_dut (
        .Clock        (clk),
        .Reset        (rst),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .SetFlags     (SetFlags),
        .Busy         (Busy),
        .Done         (Done),
        .Product      (Product),
        .ALU_A        (ALU_A),
        .ALU_B        (ALU_B),
        .ALU_FunSel   (ALU_FunSel),
        .ALU_WF       (ALU_WF),
        .ALUOut       (ALUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal shared-ALU stand-in: only the 32-bit add is meaningful here
    logic [32:0] w_sum;
    assign w_sum  = {1'b0, ALU_A} + {1'b0, ALU_B};
    assign ALUOut = (ALU_FunSel == FS_ADD32) ? w_sum[31:0] : 32'hDEAD_BEEF;

    always_ff @(posedge clk) begin
        if (ALU_WF) begin
            r_flags[FLAG_Z] <= (ALUOut == 32'd0);
            r_flags[FLAG_C] <= w_sum[32];
            r_flags[FLAG_N] <= ALUOut[31];
            r_flags[FLAG_O] <= (ALU_A[31] == ALU_B[31]) && (ALUOut[31] != ALU_A[31]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int steps_for(input logic [15:0] b);
        int n = 0;
        for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    // One complete operation, checking cycle-by-cycle status and the result
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sf);
        int n;
        logic [31:0] exp;
        n   = steps_for(b);
        exp = 32'(a) * 32'(b);
        @(negedge clk);
        Start = 1'b1; Multiplicand = a; Multiplier = b; SetFlags = sf;
        @(posedge clk); #1;
        Start = 1'b0; Multiplicand = 16'($urandom); Multiplier = 16'($urandom);
        SetFlags = 1'($urandom);
        for (int k = 0; k <= n; k++) begin
            check("busy", {31'd0, Busy}, 32'd1);
            check("done_early", {31'd0, Done}, 32'd0);
            check("wf", {31'd0, ALU_WF}, {31'd0, (k == n) ? sf : 1'b0});
            check("product_hold", Product, prev_product);
            if (k == n) begin
                check("flag_alu_a", ALU_A, exp);
                check("flag_alu_b", ALU_B, 32'd0);
            end
            @(posedge clk); #1;
        end
        check("done", {31'd0, Done}, 32'd1);
        check("busy_idle", {31'd0, Busy}, 32'd0);
        check("product", Product, exp);
        if (sf) begin
            check("flag_z", {31'd0, r_flags[FLAG_Z]}, {31'd0, exp == 32'd0});
            check("flag_n", {31'd0, r_flags[FLAG_N]}, {31'd0, exp[31]});
        end
        prev_product = exp;
        @(posedge clk); #1;
        check("done_width", {31'd0, Done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; Start = 1'b0; Multiplicand = '0; Multiplier = '0; SetFlags = 1'b0;
        prev_product = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_product", Product, 32'd0);
        check("rst_alu_a", ALU_A, 32'd0);
        check("rst_funsel", {27'd0, ALU_FunSel}, {27'd0, FS_ADD32});
        @(negedge clk); rst = 1'b0;

        run_op(16'd3, 16'd5, 1'b0);
        run_op(16'h1234, 16'h0000, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1);

        // Start held through the operation: new operands ignored until Done
        @(negedge clk);
        Start = 1'b1; Multiplicand = 16'd100; Multiplier = 16'd200; SetFlags = 1'b0;
        @(posedge clk); #1;
        Multiplicand = 16'd7; Multiplier = 16'd9;
        repeat (4) @(posedge clk);
        #1;
        check("hold_busy", {31'd0, Busy}, 32'd1);
        check("hold_product", Product, prev_product);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_done1", {31'd0, Done}, 32'd1);
        check("b2b_product1", Product, 32'd20000);
        @(posedge clk); #1;
        Start = 1'b0;
        check("b2b_accept", {31'd0, Busy}, 32'd1);
        check("b2b_done_low", {31'd0, Done}, 32'd0);
        check("b2b_hold", Product, 32'd20000);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_done2", {31'd0, Done}, 32'd1);
        check("b2b_product2", Product, 32'd63);
        prev_product = 32'd63;

        // Asynchronous reset in the middle of a STEP sequence
        @(negedge clk);
        Start = 1'b1; Multiplicand = 16'h00FF; Multiplier = 16'h0101;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_busy", {31'd0, Busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, Busy}, 32'd0);
        check("arst_done", {31'd0, Done}, 32'd0);
        check("arst_product", Product, 32'd0);
        check("arst_alu_a", ALU_A, 32'd0);
        check("arst_alu_b", ALU_B, 32'd0);
        check("arst_wf", {31'd0, ALU_WF}, 32'd0);
        check("arst_funsel", {27'd0, ALU_FunSel}, {27'd0, FS_ADD32});
        @(negedge clk); rst = 1'b0;
        prev_product = 32'd0;
        run_op(16'h00FF, 16'h0101, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom) >> $urandom_range(0, 16);
            run_op(a, b, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "timeout");
    end

endmodule : tb_alu_mul_sequencer
`default_nettype wire
